// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU definitions used by the divider and its neighbours.
//   - Width constants for single and double precision, plus selector
//     functions that pick them from an operand bus width (32 or 64).
//   - Canonical NaN, signed infinities and zero (64-bit containers;
//     single-precision patterns sit in the low 32 bits).
//   - RISC-V fflags bit positions {NV,DZ,OF,UF,NX}.
//   - Divider state encoding.
package fpu_pkg;

    localparam int MANTISSA_SIZE_SP = 23;
    localparam int EXPONENT_SIZE_SP = 8;
    localparam int BIAS_SP          = 127;
    localparam int MANTISSA_SIZE_DP = 52;
    localparam int EXPONENT_SIZE_DP = 11;
    localparam int BIAS_DP          = 1023;

    localparam logic [63:0] NAN_SP        = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] NAN_DP        = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INFINITY_P_SP = 64'h0000_0000_7F80_0000;
    localparam logic [63:0] INFINITY_N_SP = 64'h0000_0000_FF80_0000;
    localparam logic [63:0] INFINITY_P_DP = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] INFINITY_N_DP = 64'hFFF0_0000_0000_0000;
    localparam logic [63:0] ZERO          = 64'h0000_0000_0000_0000;

    localparam int FLAGS_W = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } div_state_e;

    function automatic int mantissa_size(input int bus_width);
        return (bus_width == 64) ? MANTISSA_SIZE_DP : MANTISSA_SIZE_SP;
    endfunction

    function automatic int exponent_size(input int bus_width);
        return (bus_width == 64) ? EXPONENT_SIZE_DP : EXPONENT_SIZE_SP;
    endfunction

    function automatic int exp_bias(input int bus_width);
        return (bus_width == 64) ? BIAS_DP : BIAS_SP;
    endfunction

    // Picks the single or double precision flavour of a constant.
    function automatic logic [63:0] fp_const(input int bus_width,
                                             input logic [63:0] sp,
                                             input logic [63:0] dp);
        return (bus_width == 64) ? dp : sp;
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: issue-side handshake of the floating-point divider.
//   master (FPU issue logic): drives start/in1/in2, reads busy/done/result/flags.
//   slave  (divider)        : the reverse.
interface fp_div_if
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64
);
    logic                 start;
    logic [BUS_WIDTH-1:0] in1;
    logic [BUS_WIDTH-1:0] in2;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] result;
    logic [FLAGS_W-1:0]   flags;

    modport master (
        output start, in1, in2,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, result, flags
    );
endinterface

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE-754 operand classifier (shared with the
// multiplier). Subnormals are flushed, so any zero exponent reads as zero.
//   exp_field : biased exponent field
//   man_field : stored mantissa field
//   is_zero / is_inf / is_nan : operand class
//   is_snan   : NaN with the quiet bit (mantissa MSB) clear
module fp_classify
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64
) (
    input  logic [exponent_size(BUS_WIDTH)-1:0] exp_field,
    input  logic [mantissa_size(BUS_WIDTH)-1:0] man_field,
    output logic                                is_zero,
    output logic                                is_inf,
    output logic                                is_nan,
    output logic                                is_snan
);
    localparam int MANTISSA_SIZE = mantissa_size(BUS_WIDTH);

    logic exp_ones_s;
    logic man_zero_s;

    assign exp_ones_s = &exp_field;
    assign man_zero_s = (man_field == '0);
    assign is_zero    = (exp_field == '0);
    assign is_inf     = exp_ones_s & man_zero_s;
    assign is_nan     = exp_ones_s & ~man_zero_s;
    assign is_snan    = is_nan & ~man_field[MANTISSA_SIZE-1];
endmodule

// File: rtl/fp_div.sv
// fp_div: iterative IEEE-754 divider, result = in1 / in2.
//   BUS_WIDTH 32 = single, 64 = double precision.
//   Radix-2 restoring mantissa division, one quotient bit per clock,
//   then a single round-to-nearest-even cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (abandons any divide in flight)
//   bus   : fp_div_if slave - start/in1/in2 in; busy/done/result/flags out
// Build option:
//   FP_DIV_EARLY_OUT_EN - special operands (NaN, inf, zero) go straight to
//   DONE, giving done one cycle after accept. Without it every operation
//   takes Q_BITS+2 cycles and special results are carried through.
module fp_div
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = 64
) (
    input logic     clk,
    input logic     rst_n,
    fp_div_if.slave bus
);
    localparam int MANTISSA_SIZE = mantissa_size(BUS_WIDTH);
    localparam int EXPONENT_SIZE = exponent_size(BUS_WIDTH);
    localparam int BIAS          = exp_bias(BUS_WIDTH);
    localparam int Q_BITS        = MANTISSA_SIZE + 4;
    localparam int CNT_W         = $clog2(Q_BITS);
    localparam int EW            = EXPONENT_SIZE + 2;
    localparam int RW            = MANTISSA_SIZE + 3;

    localparam logic [63:0] NAN_W   = fp_const(BUS_WIDTH, NAN_SP, NAN_DP);
    localparam logic [63:0] INF_P_W = fp_const(BUS_WIDTH, INFINITY_P_SP, INFINITY_P_DP);
    localparam logic [63:0] INF_N_W = fp_const(BUS_WIDTH, INFINITY_N_SP, INFINITY_N_DP);

    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(Q_BITS - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic signed [EW-1:0] BIAS_S     = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX_S  = EW'(2 * BIAS + 1);
    localparam logic signed [EW-1:0] EXP_ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO_S = EW'(0);

    // Operand fields
    logic                     sign1_s, sign2_s, sign_q_s;
    logic [EXPONENT_SIZE-1:0] exp1_s, exp2_s;
    logic [MANTISSA_SIZE-1:0] man1_s, man2_s;
    logic                     zero1_s, inf1_s, nan1_s, snan1_s;
    logic                     zero2_s, inf2_s, nan2_s, snan2_s;

    assign sign1_s  = bus.in1[BUS_WIDTH-1];
    assign sign2_s  = bus.in2[BUS_WIDTH-1];
    assign sign_q_s = sign1_s ^ sign2_s;
    assign exp1_s   = bus.in1[BUS_WIDTH-2 -: EXPONENT_SIZE];
    assign exp2_s   = bus.in2[BUS_WIDTH-2 -: EXPONENT_SIZE];
    assign man1_s   = bus.in1[MANTISSA_SIZE-1:0];
    assign man2_s   = bus.in2[MANTISSA_SIZE-1:0];

    fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls1 (
        .exp_field (exp1_s),
        .man_field (man1_s),
        .is_zero   (zero1_s),
        .is_inf    (inf1_s),
        .is_nan    (nan1_s),
        .is_snan   (snan1_s)
    );

    fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls2 (
        .exp_field (exp2_s),
        .man_field (man2_s),
        .is_zero   (zero2_s),
        .is_inf    (inf2_s),
        .is_nan    (nan2_s),
        .is_snan   (snan2_s)
    );

    // Registers
    div_state_e               state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [RW-1:0]            rem_r;
    logic [MANTISSA_SIZE:0]   div_r;
    logic [Q_BITS-1:0]        quo_r;
    logic signed [EW-1:0]     exp_r;
    logic                     sign_r;
    logic                     special_r;
    logic [BUS_WIDTH-1:0]     spec_res_r;
    logic [FLAGS_W-1:0]       spec_flags_r;
    logic                     busy_r;
    logic                     done_r;
    logic [BUS_WIDTH-1:0]     result_r;
    logic [FLAGS_W-1:0]       flags_r;

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.flags  = flags_r;

    logic                 special_s;
    logic [BUS_WIDTH-1:0] spec_res_s;
    logic [FLAGS_W-1:0]   spec_flags_s;
    logic [BUS_WIDTH-1:0] sgn_inf_s;
    logic [BUS_WIDTH-1:0] sgn_zero_s;
    logic signed [EW-1:0] exp_diff_s;

    assign sgn_inf_s  = sign_q_s ? INF_N_W[BUS_WIDTH-1:0] : INF_P_W[BUS_WIDTH-1:0];
    assign sgn_zero_s = {sign_q_s, {(BUS_WIDTH-1){1'b0}}};
    assign exp_diff_s = $signed({2'b00, exp1_s}) - $signed({2'b00, exp2_s}) + BIAS_S;

    // Special-operand decode at accept time; inf/x is checked before x/0 so
    // that inf/0 is a plain signed infinity without DZ.
    always_comb begin
        special_s    = 1'b1;
        spec_res_s   = '0;
        spec_flags_s = '0;
        if (nan1_s || nan2_s) begin
            spec_res_s            = NAN_W[BUS_WIDTH-1:0];
            spec_flags_s[FLAG_NV] = snan1_s | snan2_s;
        end else if ((zero1_s && zero2_s) || (inf1_s && inf2_s)) begin
            spec_res_s            = NAN_W[BUS_WIDTH-1:0];
            spec_flags_s[FLAG_NV] = 1'b1;
        end else if (inf1_s) begin
            spec_res_s = sgn_inf_s;
        end else if (zero2_s) begin
            spec_res_s            = sgn_inf_s;
            spec_flags_s[FLAG_DZ] = 1'b1;
        end else if (zero1_s || inf2_s) begin
            spec_res_s = sgn_zero_s;
        end else begin
            special_s = 1'b0;
        end
    end

    logic          rem_ge_s;
    logic [RW-1:0] rem_sub_s;

    // One restoring-division step: subtract the divisor when it fits.
    always_comb begin
        rem_ge_s = (rem_r >= {2'b00, div_r});
        if (rem_ge_s) begin
            rem_sub_s = rem_r - {2'b00, div_r};
        end else begin
            rem_sub_s = rem_r;
        end
    end

    logic [Q_BITS-2:0]        frac_s;
    logic signed [EW-1:0]     exp_n_s;
    logic signed [EW-1:0]     exp_f_s;
    logic                     lsb_s, g_s, r_s, s_s, rnd_s;
    logic [MANTISSA_SIZE:0]   mant_rnd_s;
    logic [BUS_WIDTH-1:0]     rnd_res_s;
    logic [FLAGS_W-1:0]       rnd_flags_s;

    // Normalise, round to nearest even, then range-check the exponent.
    // frac_s holds the bits below the leading one: mantissa, G, R, S-bit.
    always_comb begin
        if (quo_r[Q_BITS-1]) begin
            frac_s  = quo_r[Q_BITS-2:0];
            exp_n_s = exp_r;
        end else begin
            frac_s  = {quo_r[Q_BITS-3:0], 1'b0};
            exp_n_s = exp_r - EXP_ONE_S;
        end
        lsb_s      = frac_s[3];
        g_s        = frac_s[2];
        r_s        = frac_s[1];
        s_s        = frac_s[0] | (rem_r != '0);
        rnd_s      = g_s & (lsb_s | r_s | s_s);
        mant_rnd_s = {1'b0, frac_s[Q_BITS-2:3]} + {{MANTISSA_SIZE{1'b0}}, rnd_s};
        // A carry out means the mantissa wrapped to 1.0 of the next binade.
        exp_f_s    = exp_n_s + $signed({{(EW-1){1'b0}}, mant_rnd_s[MANTISSA_SIZE]});
        rnd_flags_s = '0;
        if (exp_f_s >= EXP_MAX_S) begin
            rnd_res_s            = sign_r ? INF_N_W[BUS_WIDTH-1:0] : INF_P_W[BUS_WIDTH-1:0];
            rnd_flags_s[FLAG_OF] = 1'b1;
            rnd_flags_s[FLAG_NX] = 1'b1;
        end else if (exp_f_s <= EXP_ZERO_S) begin
            rnd_res_s            = {sign_r, {(BUS_WIDTH-1){1'b0}}};
            rnd_flags_s[FLAG_UF] = 1'b1;
            rnd_flags_s[FLAG_NX] = 1'b1;
        end else begin
            rnd_res_s            = {sign_r, exp_f_s[EXPONENT_SIZE-1:0],
                                    mant_rnd_s[MANTISSA_SIZE-1:0]};
            rnd_flags_s[FLAG_NX] = g_s | r_s | s_s;
        end
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            rem_r        <= '0;
            div_r        <= '0;
            quo_r        <= '0;
            exp_r        <= '0;
            sign_r       <= 1'b0;
            special_r    <= 1'b0;
            spec_res_r   <= '0;
            spec_flags_r <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            result_r     <= '0;
            flags_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sign_r       <= sign_q_s;
                        exp_r        <= exp_diff_s;
                        rem_r        <= {2'b01, man1_s};
                        div_r        <= {1'b1, man2_s};
                        quo_r        <= '0;
                        cnt_r        <= '0;
                        special_r    <= special_s;
                        spec_res_r   <= spec_res_s;
                        spec_flags_r <= spec_flags_s;
`ifdef FP_DIV_EARLY_OUT_EN
                        if (special_s) begin
                            result_r <= spec_res_s;
                            flags_r  <= spec_flags_s;
                            done_r   <= 1'b1;
                            busy_r   <= 1'b0;
                            state_r  <= ST_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= ST_DIVIDE;
                        end
`else
                        busy_r  <= 1'b1;
                        state_r <= ST_DIVIDE;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DIVIDE: begin
                    quo_r <= {quo_r[Q_BITS-2:0], rem_ge_s};
                    rem_r <= rem_sub_s << 1;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_ROUND;
                    end else begin
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_ROUND: begin
                    if (special_r) begin
                        result_r <= spec_res_r;
                        flags_r  <= spec_flags_r;
                    end else begin
                        result_r <= rnd_res_s;
                        flags_r  <= rnd_flags_s;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: self-checking bench for fp_div (single and double instances).
// Expected results are queued when an operation is issued and compared by a
// monitor when done pulses, together with the done cycle.
module tb_fp_div;
    import fpu_pkg::*;

    localparam int LAT32 = 29;
    localparam int LAT64 = 58;
`ifdef FP_DIV_EARLY_OUT_EN
    localparam int LAT_SPEC32 = 1;
`else
    localparam int LAT_SPEC32 = LAT32;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_div_if #(.BUS_WIDTH(32)) bus32 ();
    fp_div_if #(.BUS_WIDTH(64)) bus64 ();

    fp_div #(.BUS_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    fp_div #(.BUS_WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flags;
        int          lat;
        int          acc;
    } sb_entry_t;

    sb_entry_t sb32[$];
    sb_entry_t sb64[$];
    sb_entry_t e32, e64;
    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: every done pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (bus32.done === 1'b1) begin
            if (sb32.size() == 0) begin
                check_eq("done32_spurious", 64'(bus32.done), 64'd0);
            end else begin
                e32 = sb32.pop_front();
                check_eq("res32", 64'(bus32.result), e32.res);
                check_eq("flags32", 64'(bus32.flags), 64'(e32.flags));
                check_eq("lat32", 64'(edge_cnt - e32.acc + 1), 64'(e32.lat));
            end
        end
        if (bus64.done === 1'b1) begin
            if (sb64.size() == 0) begin
                check_eq("done64_spurious", 64'(bus64.done), 64'd0);
            end else begin
                e64 = sb64.pop_front();
                check_eq("res64", bus64.result, e64.res);
                check_eq("flags64", 64'(bus64.flags), 64'(e64.flags));
                check_eq("lat64", 64'(edge_cnt - e64.acc + 1), 64'(e64.lat));
            end
        end
    end

    // Drives one start pulse; returns at the falling edge of cycle 1.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [4:0] fl, input bit spec);
        sb_entry_t e;
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.in1   = a;
        bus32.in2   = b;
        e.res   = {32'h0, res};
        e.flags = fl;
        e.lat   = spec ? LAT_SPEC32 : LAT32;
        e.acc   = edge_cnt + 1;
        sb32.push_back(e);
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] res, input logic [4:0] fl);
        sb_entry_t e;
        @(negedge clk);
        bus64.start = 1'b1;
        bus64.in1   = a;
        bus64.in2   = b;
        e.res   = res;
        e.flags = fl;
        e.lat   = LAT64;
        e.acc   = edge_cnt + 1;
        sb64.push_back(e);
        @(negedge clk);
        bus64.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb32.size() == 0 && sb64.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain", 64'(sb32.size() + sb64.size()), 64'd0);
        sb32.delete();
        sb64.delete();
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [4:0] fl, input bit spec);
        issue32(a, b, res, fl, spec);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus32.start = 1'b0;
        bus32.in1   = 32'h0;
        bus32.in2   = 32'h0;
        bus64.start = 1'b0;
        bus64.in1   = 64'h0;
        bus64.in2   = 64'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(bus32.busy), 64'd0);
        check_eq("rst_done", 64'(bus32.done), 64'd0);
        check_eq("rst_result", 64'(bus32.result), 64'd0);
        check_eq("rst_flags", 64'(bus32.flags), 64'd0);
        check_eq("rst_result64", bus64.result, 64'd0);
        rst_n = 1'b1;

        // 6/2 with busy window checks
        issue32(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 1'b0);
        check_eq("busy_c1", 64'(bus32.busy), 64'd1);
        repeat (27) @(negedge clk);
        check_eq("busy_c28", 64'(bus32.busy), 64'd1);
        @(negedge clk);
        check_eq("busy_c29", 64'(bus32.busy), 64'd0);
        drain();

        // Normal arithmetic, rounding and range boundaries
        run32(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 1'b0);
        run32(32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00, 1'b0);
        run32(32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 5'h01, 1'b0);
        run32(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'h05, 1'b0);
        run32(32'h00800000, 32'h4F800000, 32'h00000000, 5'h03, 1'b0);
        run32(32'h7F000000, 32'h3F800000, 32'h7F000000, 5'h00, 1'b0);
        run32(32'h00800000, 32'h3F800000, 32'h00800000, 5'h00, 1'b0);

        // Special operands
        run32(32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1'b1);
        run32(32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 1'b1);
        run32(32'hFF800000, 32'h7F800000, 32'h7FC00000, 5'h10, 1'b1);
        run32(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 1'b1);
        run32(32'h3F800000, 32'h7F800001, 32'h7FC00000, 5'h10, 1'b1);
        run32(32'hFF800000, 32'h00000000, 32'hFF800000, 5'h00, 1'b1);
        run32(32'h00000000, 32'hC0000000, 32'h80000000, 5'h00, 1'b1);
        run32(32'h40000000, 32'hFF800000, 32'h80000000, 5'h00, 1'b1);
        run32(32'h00000001, 32'h3F800000, 32'h00000000, 5'h00, 1'b1);

        // Second start while busy must be ignored
        issue32(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 1'b0);
        repeat (9) @(negedge clk);
        bus32.start = 1'b1;
        bus32.in1   = 32'h3F800000;
        bus32.in2   = 32'h40400000;
        @(negedge clk);
        bus32.start = 1'b0;
        drain();
        repeat (35) @(negedge clk);

        // Reset in the middle of a divide
        issue32(32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        sb32.delete();
        @(negedge clk);
        check_eq("midrst_busy", 64'(bus32.busy), 64'd0);
        check_eq("midrst_done", 64'(bus32.done), 64'd0);
        check_eq("midrst_result", 64'(bus32.result), 64'd0);
        check_eq("midrst_flags", 64'(bus32.flags), 64'd0);
        rst_n = 1'b1;
        run32(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 1'b0);

        // Double precision
        issue64(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'h01);
        drain();
        issue64(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'h00);
        drain();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Iterative IEEE-754 floating-point divider: in1 / in2, single or double precision selected by BUS_WIDTH.
- Sits in the FPU beside the combinational multiplier and performs the inverse operation.
- Sequential radix-2 restoring mantissa divider, one quotient bit per clock.
- start/done handshake to the FPU issue logic. Returns the result plus RISC-V fflags.

Parameters:
- BUS_WIDTH, 64, operand width; 64 = double, 32 = single (derives MANTISSA_SIZE 52/23, EXPONENT_SIZE 11/8, BIAS 1023/127).
- Q_BITS, MANTISSA_SIZE+4 (localparam), quotient bits generated: 1 integer bit + mantissa + guard + round + 1 normalisation bit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- in1  in  BUS_WIDTH  dividend.
- in2  in  BUS_WIDTH  divisor.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: result/flags valid.
- result  out  BUS_WIDTH  quotient; held until next accepted start.
- flags  out  5  {NV,DZ,OF,UF,NX}, held with result.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; busy=0, done=0, result=0, flags=0. Applies mid-operation: the in-flight divide is abandoned and no done is issued.
- States: IDLE -> DIVIDE -> ROUND -> DONE -> IDLE.
- IDLE: on start, latch operands, classify, go to DIVIDE; busy=1 from the next cycle. start while busy=1 is ignored, with no queuing.
- Classification: exponent 0 is treated as zero (subnormals flushed). Exponent all-ones with mantissa 0 is inf; with mantissa nonzero it is NaN.
- Special cases, with sign = S1^S2 unless NaN:
  - NaN in, 0/0, or inf/inf: canonical NaN (0x7FC00000 / 0x7FF8000000000000); NV only if either operand is NaN with mantissa MSB=0, or for 0/0 and inf/inf.
  - x/0 with x finite nonzero: signed inf, DZ.
  - inf/finite: signed inf.
  - 0/nonzero or finite/inf: signed zero.
  - Special results bypass iteration but still spend Q_BITS cycles in DIVIDE (see Optional Feature).
- DIVIDE: remainder register = {1, M_1} (width MANTISSA_SIZE+3); divisor = {1, M_2}.
  - Each cycle: shift the quotient left; if rem >= div, then rem -= div and the quotient LSB = 1; then rem <<= 1.
  - Cycle counter runs 0..Q_BITS-1, then ROUND.
- ROUND:
  - If quotient MSB=0, shift left 1 and exp -= 1.
  - Exponent = E1 - E2 + BIAS, computed signed at EXPONENT_SIZE+2 bits.
  - Round to nearest even: round = G & (L | R | S), where S = remaining quotient bits OR (rem != 0).
  - A mantissa carry-out renormalises and increments exp.
  - exp >= 2*BIAS+1 gives signed inf with OF, NX.
  - exp <= 0 gives signed zero with UF, NX.
  - Otherwise NX = G|R|S.
- DONE: drive result/flags; done=1 for exactly this cycle; busy=0 in this cycle; next state IDLE. A start in the DONE cycle is not accepted; it is accepted only in IDLE.
- Latency: start accepted at edge 0; done high in cycle Q_BITS+2 (single: 29, double: 58).

Optional Feature:
- Macro: FP_DIV_EARLY_OUT_EN.
- Defined: special-case operands skip DIVIDE/ROUND. IDLE -> DONE, with done in cycle 1 after the accepting edge.
- Undefined: every operation has fixed latency Q_BITS+2; special results are computed at accept time and held through DIVIDE/ROUND.

Decomposition:
- Package fpu_pkg holds:
  - width localparams (MANTISSA_SIZE, EXPONENT_SIZE, BIAS per BUS_WIDTH);
  - NAN / INFINITY_P / INFINITY_N / ZERO constants;
  - fflags bit indices;
  - state encoding.
- One sub-module, fp_classify: combinational, outputs is_zero/is_inf/is_nan/is_snan per operand. Reusable by the multiplier.

Test Plan (BUS_WIDTH=32 unless stated):
- 0x40C00000 / 0x40000000 (6/2) -> result 0x40400000, flags 0x00, done exactly at cycle 29, busy high cycles 1..28.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flags 0x01. BUS_WIDTH=64: 0x3FF0000000000000 / 0x4008000000000000 -> 0x3FD5555555555555, flags 0x01, done at cycle 58.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, flags 0x08.
  - 0/0 -> 0x7FC00000, flags 0x10.
  - 0xFF800000 / 0x7F800000 -> 0x7FC00000, flags 0x10.
  - Run each with and without FP_DIV_EARLY_OUT_EN; done at cycle 1 vs 29.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, flags 0x05. 0x00800000 / 0x4F800000 -> 0x00000000, flags 0x03.
- start pulsed again at cycle 10 with different operands -> ignored; first result 0x40400000 unchanged at cycle 29.
- rst_n low at cycle 15 of a divide -> busy=0, done never pulses, result=0. A new start next cycle completes normally.
